mcu_reset_supervisor: RTL

MCU_RESET_SUPERVISOR -- requirements
Module: mcu_reset_supervisor

---
 rtl/mcu_reset_supervisor.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/mcu_reset_supervisor.sv
// Purpose: sequences the MCU reset from PLL lock, core lockup and an optional heartbeat watchdog (`MCU_RESET_SUPERVISOR_WDT_EN).
// Latency: MCU_RSTN releases 2 + LOCK_WAIT + RST_HOLD cycles after PLL lock; a fault drives MCU_RSTN low on the next cycle.
// Backpressure: none; status inputs are sampled every cycle and all outputs are registered.
module mcu_reset_supervisor #(
    parameter int LOCK_WAIT   = 1024,
    parameter int RST_HOLD    = 64,
    parameter int LOCKUP_FILT = 16,
    parameter int WDT_TIMEOUT = 1048576
) (
    input  logic       HCLK,
    input  logic       hwRst,
    input  logic       PLL_LOCK,
    input  logic       LOCKUP,
    input  logic       HALTED,
    input  logic       HEARTBEAT,
    output logic       MCU_RSTN,
    output logic       SYS_READY,
    output logic [1:0] RST_CAUSE,
    output logic [7:0] RST_COUNT
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_LOCK   = 2'd1;
    localparam logic [1:0] CAUSE_LOCKUP = 2'd2;
    localparam logic [1:0] CAUSE_WDT    = 2'd3;

    localparam int LW_W = (LOCK_WAIT   > 1) ? $clog2(LOCK_WAIT)   : 1;
    localparam int RH_W = (RST_HOLD    > 1) ? $clog2(RST_HOLD)    : 1;
    localparam int LF_W = (LOCKUP_FILT > 1) ? $clog2(LOCKUP_FILT) : 1;

    localparam logic [LW_W-1:0] LW_LAST = LW_W'(LOCK_WAIT - 1);
    localparam logic [RH_W-1:0] RH_LAST = RH_W'(RST_HOLD - 1);
    localparam logic [LF_W-1:0] LF_LAST = LF_W'(LOCKUP_FILT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        lock_sync;
    logic              lock_s;
    logic [LW_W-1:0]   stable_cnt;
    logic [RH_W-1:0]   hold_cnt;
    logic [LF_W-1:0]   lockup_cnt;
    logic              lockup_fire;
    logic              wdt_expire;
    logic [1:0]        cause_nxt;
    logic [7:0]        count_nxt;
    logic              fault_hit;

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge HCLK or posedge hwRst) begin
        if (hwRst) begin
            lock_sync <= 2'b00;
        end else begin
            lock_sync <= {lock_sync[0], PLL_LOCK};
        end
    end

    assign lock_s = lock_sync[1];

`ifdef MCU_RESET_SUPERVISOR_WDT_EN
    localparam int WD_W = (WDT_TIMEOUT > 1) ? $clog2(WDT_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDT_TIMEOUT - 1);

    logic [1:0]      hb_sync;
    logic            hb_prev;
    logic            hb_edge;
    logic [WD_W-1:0] wdt_cnt;

    // Two-flop synchroniser plus one history flop so either heartbeat edge can be seen.
    always_ff @(posedge HCLK or posedge hwRst) begin
        if (hwRst) begin
            hb_sync <= 2'b00;
            hb_prev <= 1'b0;
        end else begin
            hb_sync <= {hb_sync[0], HEARTBEAT};
            hb_prev <= hb_sync[1];
        end
    end

    assign hb_edge = hb_sync[1] ^ hb_prev;

    // Watchdog age: reloads on heartbeat, freezes under debug halt, cleared whenever not running.
    always_ff @(posedge HCLK or posedge hwRst) begin
        if (hwRst) begin
            wdt_cnt <= '0;
        end else if ((state == RUN) && (state_nxt == RUN)) begin
            if (hb_edge) begin
                wdt_cnt <= '0;
            end else if (!HALTED) begin
                wdt_cnt <= wdt_cnt + WD_W'(1);
            end
        end else begin
            wdt_cnt <= '0;
        end
    end

    assign wdt_expire = (state == RUN) && !hb_edge && !HALTED && (wdt_cnt == WD_LAST);
`else
    logic unused_wdt_inputs;

    // Without the watchdog the heartbeat and halt inputs have no effect.
    assign unused_wdt_inputs = HEARTBEAT ^ HALTED ^ (WDT_TIMEOUT > 0);
    assign wdt_expire        = 1'b0;
`endif

    assign lockup_fire = (state == RUN) && LOCKUP && (lockup_cnt == LF_LAST);

    // Next-state, cause and event count; lock loss outranks lockup, which outranks the watchdog.
    always_comb begin
        state_nxt = state;
        cause_nxt = RST_CAUSE;
        fault_hit = 1'b0;
        count_nxt = RST_COUNT;
        case (state)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = STABLE;
                end
            end
            STABLE: begin
                // The MCU has not been released in this sequence yet, so a
                // glitch here only restarts the lock qualification.
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (stable_cnt == LW_LAST) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cause_nxt = CAUSE_LOCK;
                    fault_hit = 1'b1;
                end else if (hold_cnt == RH_LAST) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cause_nxt = CAUSE_LOCK;
                    fault_hit = 1'b1;
                end else if (lockup_fire) begin
                    state_nxt = HOLD;
                    cause_nxt = CAUSE_LOCKUP;
                    fault_hit = 1'b1;
                end else if (wdt_expire) begin
                    state_nxt = HOLD;
                    cause_nxt = CAUSE_WDT;
                    fault_hit = 1'b1;
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
            end
        endcase
        if (fault_hit && (RST_COUNT != 8'hFF)) begin
            count_nxt = RST_COUNT + 8'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge HCLK or posedge hwRst) begin
        if (hwRst) begin
            state <= WAIT_LOCK;
        end else begin
            state <= state_nxt;
        end
    end

    // Lock qualification counter: counts consecutive synced-lock cycles spent in STABLE.
    always_ff @(posedge HCLK or posedge hwRst) begin
        if (hwRst) begin
            stable_cnt <= '0;
        end else if ((state == STABLE) && (state_nxt == STABLE)) begin
            stable_cnt <= stable_cnt + LW_W'(1);
        end else begin
            stable_cnt <= '0;
        end
    end

    // Reset pulse width counter, restarted on every entry to HOLD.
    always_ff @(posedge HCLK or posedge hwRst) begin
        if (hwRst) begin
            hold_cnt <= '0;
        end else if ((state == HOLD) && (state_nxt == HOLD)) begin
            hold_cnt <= hold_cnt + RH_W'(1);
        end else begin
            hold_cnt <= '0;
        end
    end

    // Lockup filter: consecutive LOCKUP cycles while running; any low cycle or leaving RUN clears it.
    always_ff @(posedge HCLK or posedge hwRst) begin
        if (hwRst) begin
            lockup_cnt <= '0;
        end else if ((state == RUN) && (state_nxt == RUN) && LOCKUP) begin
            lockup_cnt <= lockup_cnt + LF_W'(1);
        end else begin
            lockup_cnt <= '0;
        end
    end

    // Registered outputs, derived from the next state so they line up with the state register.
    always_ff @(posedge HCLK or posedge hwRst) begin
        if (hwRst) begin
            MCU_RSTN  <= 1'b0;
            SYS_READY <= 1'b0;
            RST_CAUSE <= 2'd0;
            RST_COUNT <= 8'd0;
        end else begin
            MCU_RSTN  <= (state_nxt == RUN);
            SYS_READY <= (state_nxt == RUN);
            RST_CAUSE <= cause_nxt;
            RST_COUNT <= count_nxt;
        end
    end

endmodule
